// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare predictor, its resolve queue and the bench.
package gshare_pkg;

  localparam int ADDR_W = 11;
  localparam int GHR_W  = 4;

  // One in-flight prediction: the PHT index it used, the predicted direction,
  // and the history snapshot needed to rebuild the GHR on a mispredict.
  typedef struct packed {
    logic [GHR_W-1:0] index;
    logic             taken;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  function automatic logic [GHR_W-1:0] gshare_index(input logic [ADDR_W-1:0] addr,
                                                    input logic [GHR_W-1:0]  ghr);
    return addr[GHR_W-1:0] ^ ghr;
  endfunction

endpackage

// File: rtl/gshare_resolve_queue_if.sv
// Handshake bundle between the gshare predictor and its resolve queue.
// master = predictor/branch-unit side, slave = the resolve queue.
interface gshare_resolve_queue_if #(
  parameter int ADDR_W = gshare_pkg::ADDR_W,
  parameter int GHR_W  = gshare_pkg::GHR_W
);

  logic              pred_valid;
  logic [ADDR_W-1:0] pred_addr;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_ghr;
  logic              pred_ready;

  logic              res_valid;
  logic              res_taken;
  logic              res_ready;

  logic              upd_valid;
  logic [GHR_W-1:0]  upd_index;
  logic              upd_taken;
  logic              flush;
  logic [GHR_W-1:0]  restore_ghr;

  modport master (
    output pred_valid, pred_addr, pred_taken, pred_ghr, res_valid, res_taken,
    input  pred_ready, res_ready, upd_valid, upd_index, upd_taken, flush, restore_ghr
  );

  modport slave (
    input  pred_valid, pred_addr, pred_taken, pred_ghr, res_valid, res_taken,
    output pred_ready, res_ready, upd_valid, upd_index, upd_taken, flush, restore_ghr
  );

endinterface

// File: rtl/gshare_fifo.sv
// Small synchronous FIFO; clear has priority over push/pop.
module gshare_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/gshare_resolve_queue.sv
// Holds issued gshare predictions until they resolve in order; emits PHT
// training, flush/GHR repair on mispredict, and branch statistics.
module gshare_resolve_queue #(
  parameter  int ADDR_W = gshare_pkg::ADDR_W,
  parameter  int GHR_W  = gshare_pkg::GHR_W,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  gshare_resolve_queue_if.slave bus,
  output logic [OCC_W-1:0]    occupancy,
  output logic [CNT_W-1:0]    branch_count,
  output logic [CNT_W-1:0]    mispredict_count
);

  localparam int ENTRY_W = 2 * GHR_W + 1;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic [GHR_W-1:0]   head_index;
  logic               head_taken;
  logic [GHR_W-1:0]   head_ghr;
  logic               full;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic               mispredict;

  logic               upd_valid_q;
  logic [GHR_W-1:0]   upd_index_q;
  logic               upd_taken_q;
  logic               flush_q;
  logic [GHR_W-1:0]   restore_ghr_q;

  // Only the low address bits feed the index; the MSB of the snapshot is
  // shifted out when the history is rebuilt.
  logic unused_bits;
  assign unused_bits = ^{bus.pred_addr[ADDR_W-1:GHR_W], head_ghr[GHR_W-1]};

  // Entry layout matches gshare_pkg::entry_t: {index, taken, ghr}.
  assign wr_entry   = {bus.pred_addr[GHR_W-1:0] ^ bus.pred_ghr, bus.pred_taken, bus.pred_ghr};
  assign head_index = head[ENTRY_W-1 -: GHR_W];
  assign head_taken = head[GHR_W];
  assign head_ghr   = head[GHR_W-1:0];

  assign push_ok    = bus.pred_valid && !full;
  assign pop_ok     = bus.res_valid && !empty;
  assign mispredict = pop_ok && (head_taken != bus.res_taken);

  // A mispredict clears the queue and wins over any same-cycle push.
  gshare_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_ok && !mispredict),
    .pop     (pop_ok),
    .clear   (mispredict),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

  assign bus.pred_ready  = !full;
  assign bus.res_ready   = !empty;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.flush       = flush_q;
  assign bus.restore_ghr = restore_ghr_q;

  // Register the training update and GHR repair one cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      restore_ghr_q <= '0;
    end else begin
      upd_valid_q <= pop_ok;
      flush_q     <= mispredict;
      if (pop_ok) begin
        upd_index_q <= head_index;
        upd_taken_q <= bus.res_taken;
      end
      if (mispredict) restore_ghr_q <= {head_ghr[GHR_W-2:0], bus.res_taken};
    end
  end

  // Saturating branch / mispredict statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop_ok && (branch_count != {CNT_W{1'b1}}))
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict && (mispredict_count != {CNT_W{1'b1}}))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gshare_resolve_queue.sv
// Directed bench with a reference queue model and an expected-update scoreboard.
module tb_gshare_resolve_queue;
  import gshare_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [GHR_W-1:0] idx;
    logic             tk;
    logic             fl;
    logic [GHR_W-1:0] rg;
  } exp_t;

  logic clk;
  logic reset;

  logic [2:0]  occ;
  logic [15:0] br_cnt;
  logic [15:0] mis_cnt;
  logic [2:0]  occ_s;
  logic [3:0]  br_cnt_s;
  logic [3:0]  mis_cnt_s;

  gshare_resolve_queue_if bus ();
  gshare_resolve_queue_if bus_s ();

  gshare_resolve_queue u_dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .occupancy        (occ),
    .branch_count     (br_cnt),
    .mispredict_count (mis_cnt)
  );

  // Narrow counters so saturation is reachable in a short run.
  gshare_resolve_queue #(.CNT_W(4)) u_dut_sat (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus_s),
    .occupancy        (occ_s),
    .branch_count     (br_cnt_s),
    .mispredict_count (mis_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passed;
  int          total;
  exp_t        sb[$];
  entry_t      mq[$];
  logic [15:0] m_br;
  logic [15:0] m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("upd_valid", 32'(bus.upd_valid), 32'(1'b1));
      chk("upd_index", 32'(bus.upd_index), 32'(e.idx));
      chk("upd_taken", 32'(bus.upd_taken), 32'(e.tk));
      chk("flush", 32'(bus.flush), 32'(e.fl));
      if (e.fl) chk("restore_ghr", 32'(bus.restore_ghr), 32'(e.rg));
    end else begin
      chk("upd_idle", 32'(bus.upd_valid), 32'(1'b0));
      chk("flush_idle", 32'(bus.flush), 32'(1'b0));
    end
    chk("occupancy", 32'(occ), 32'(mq.size()));
    chk("pred_ready", 32'(bus.pred_ready), 32'(mq.size() != DEPTH));
    chk("res_ready", 32'(bus.res_ready), 32'(mq.size() != 0));
    chk("branch_count", 32'(br_cnt), 32'(m_br));
    chk("mispredict_count", 32'(mis_cnt), 32'(m_mis));
  endtask

  // One clock of stimulus: model the edge, then compare just after it.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] a, input logic pt,
                      input logic [GHR_W-1:0] g, input logic rv, input logic rt);
    entry_t h;
    exp_t   e;
    logic   mis;
    logic   can_push;
    bus.pred_valid = pv;
    bus.pred_addr  = a;
    bus.pred_taken = pt;
    bus.pred_ghr   = g;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    mis      = 1'b0;
    can_push = (mq.size() != DEPTH);
    if (rv && mq.size() != 0) begin
      h     = mq.pop_front();
      mis   = (h.taken != rt);
      e.idx = h.index;
      e.tk  = rt;
      e.fl  = mis;
      e.rg  = {h.ghr[GHR_W-2:0], rt};
      sb.push_back(e);
      if (m_br != 16'hFFFF) m_br++;
      if (mis) begin
        if (m_mis != 16'hFFFF) m_mis++;
        mq.delete();
      end
    end
    if (pv && can_push && !mis) begin
      h.index = gshare_index(a, g);
      h.taken = pt;
      h.ghr   = g;
      mq.push_back(h);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_br   = '0;
    m_mis  = '0;
    reset  = 1'b0;
    bus.pred_valid = 1'b0; bus.pred_addr = '0; bus.pred_taken = 1'b0; bus.pred_ghr = '0;
    bus.res_valid  = 1'b0; bus.res_taken = 1'b0;
    bus_s.pred_valid = 1'b0; bus_s.pred_addr = '0; bus_s.pred_taken = 1'b0; bus_s.pred_ghr = '0;
    bus_s.res_valid  = 1'b0; bus_s.res_taken = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_upd_index", 32'(bus.upd_index), 32'(0));
    chk("rst_upd_taken", 32'(bus.upd_taken), 32'(0));
    chk("rst_restore", 32'(bus.restore_ghr), 32'(0));
    reset = 1'b1;
    idle();

    // Correct prediction
    step(1'b1, 11'h005, 1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("corr_index", 32'(bus.upd_index), 32'(4'b0110));
    idle();

    // Fill, overflow push, pop with push while full
    for (int i = 0; i < 4; i++) step(1'b1, 11'(32'h100 + i), 1'b1, 4'(i), 1'b0, 1'b0);
    chk("fill_occ", 32'(occ), 32'(4));
    chk("fill_ready", 32'(bus.pred_ready), 32'(0));
    step(1'b1, 11'h1FF, 1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 11'h0AA, 1'b1, 4'h5, 1'b1, 1'b1);
    chk("pop_full_occ", 32'(occ), 32'(3));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle();

    // Mispredict with same-cycle push
    step(1'b1, 11'h020, 1'b1, 4'b1010, 1'b0, 1'b0);
    step(1'b1, 11'h021, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 11'h022, 1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 11'h033, 1'b1, 4'b0111, 1'b1, 1'b0);
    chk("mis_restore", 32'(bus.restore_ghr), 32'(4'b0100));
    chk("mis_occ", 32'(occ), 32'(0));
    idle();

    // Resolve while empty
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle();

    // Pointer wrap with streaming push/pop
    step(1'b1, 11'h3C1, 1'b0, 4'h9, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 11'(i * 37), i[0], 4'(i * 3), 1'b1, mq[0].taken);
    step(1'b0, '0, 1'b0, '0, 1'b1, mq[0].taken);
    idle();

    // Reset mid-operation
    step(1'b1, 11'h011, 1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 11'h012, 1'b0, 4'h2, 1'b0, 1'b0);
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_occ", 32'(occ), 32'(0));
    chk("midrst_res_ready", 32'(bus.res_ready), 32'(0));
    chk("midrst_pred_ready", 32'(bus.pred_ready), 32'(1));
    chk("midrst_br", 32'(br_cnt), 32'(0));
    mq.delete();
    sb.delete();
    m_br  = '0;
    m_mis = '0;
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;
    idle();

    // Counter saturation on the narrow-counter instance
    for (int i = 1; i <= 20; i++) begin
      bus_s.pred_valid = 1'b1;
      bus_s.pred_taken = 1'b1;
      bus_s.pred_addr  = 11'(i);
      bus_s.pred_ghr   = 4'(i);
      bus_s.res_valid  = 1'b0;
      @(posedge clk);
      #1;
      bus_s.pred_valid = 1'b0;
      bus_s.res_valid  = 1'b1;
      bus_s.res_taken  = 1'b0;
      @(posedge clk);
      #1;
      bus_s.res_valid = 1'b0;
      chk("sat_flush", 32'(bus_s.flush), 32'(1));
      if (i == 14) begin
        chk("sat_br_14", 32'(br_cnt_s), 32'(14));
        chk("sat_mis_14", 32'(mis_cnt_s), 32'(14));
      end
      if (i == 20) begin
        chk("sat_br_max", 32'(br_cnt_s), 32'(4'hF));
        chk("sat_mis_max", 32'(mis_cnt_s), 32'(4'hF));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
